uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver for the MIDI/serial front end. It supports configurable data width, parity, stop bits and oversampling, and uses majority-vote sampling. Frame, parity and overrun errors are reported separately, and line breaks are detected. Output uses a valid/ready handshake with a one-word holding register, so a stalled consumer produces an overrun report instead of silent loss.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 31_250, line bit rate (MIDI default)
OVERSAMPLE, 16, ticks per bit; even, ≥ 8
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_in  in  1  raw UART line (asynchronous, idle high)
valid  out  1  d_out holds an unconsumed word
ready  in  1  consumer accepts the word when valid && ready
d_out  out  DATA_BITS  received data, LSB = first bit on the line
f_error  out  1  frame error for the word in d_out (stop sample = 0)
p_error  out  1  parity error for the word in d_out (0 when PARITY = 0)
brk  out  1  word in d_out is a break (all data = 0, parity/stop = 0)
o_error  out  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, synchroniser flops are 1, prescaler is 0. Reset can be asserted mid-frame; the partial frame is discarded with no o_error.
- rx_in passes through a 2-FF synchroniser (rx_s). All logic uses rx_s.
- Prescaler: DIV = CLK_FREQ / (BAUD * OVERSAMPLE), integer division. DIV < 1 is an elaboration error.
  - tick is high for 1 clk every DIV clks.
  - In IDLE, the prescaler and sub-bit counter (0..OVERSAMPLE-1) are cleared on the clk where rx_s = 0 is first seen.
- Sampling: bit value = majority of rx_s at sub-bit counts M-1, M, M+1, where M = OVERSAMPLE/2. The decision is made at count M+1.
- States: IDLE, START, DATA, PAR, STOP, BRK_WAIT.
  - IDLE -> START when rx_s = 0.
  - START: a majority of 1 is a false start -> IDLE, no output. Otherwise -> DATA.
  - DATA: shifts in DATA_BITS LSB-first, one bit per OVERSAMPLE ticks. -> PAR if PARITY != 0, else -> STOP.
  - PAR: p_err_int = 1 if data ones + parity bit is even (odd mode) or odd (even mode).
  - STOP: samples STOP_BITS bits. f_err_int = 1 if any stop sample = 0. The frame completes at the mid-sample of the last stop bit.
  - After completion: -> BRK_WAIT if data = 0 and f_err_int = 1 (and the parity sample = 0 when present). Otherwise -> IDLE immediately, which allows back-to-back frames with up to half a bit of timing slack.
  - BRK_WAIT -> IDLE when rx_s = 1.
- Completion, evaluated on the clk after the last stop decision:
  - If valid = 0, or valid && ready in that same clk: load d_out, f_error, p_error, brk; valid = 1.
  - If valid = 1 && ready = 0: drop the new frame, keep the held word unchanged, pulse o_error for 1 clk.
- Handshake: valid && ready with no simultaneous completion -> valid = 0 on the next clk. d_out and the error flags hold their values while valid = 1 and are don't-care when valid = 0.
- Latency: valid rises DIV*OVERSAMPLE*(1 + DATA_BITS + P + STOP_BITS - 1) + DIV*(M+1) + 3 clks (±DIV) after the rx_in falling edge, where P = 1 if PARITY != 0.
- Stop bits beyond the sample point are not checked for their full duration.

Test Plan:
Defaults are used except where stated. DIV = 100, bit time = 1600 clk.
1. Loopback through existing uart_tx, bytes 0x10..0x19 back-to-back, ready tied 1 -> 10 valid pulses, d_out = 0x10..0x19 in order, all error flags 0, no o_error.
2. Glitch: rx_in low for 300 clk then high -> no valid, FSM returns to IDLE, next frame 0xA5 received correctly.
3. PARITY = 2, frame 0x03 sent with parity bit 1 -> valid with d_out = 0x03, p_error = 1. Repeat with parity bit 0 -> p_error = 0. PARITY = 1 gives the inverse results.
4. Stop bit forced 0 on frame 0x55 -> f_error = 1, brk = 0. Line held low for 20 bit times -> one word with d_out = 0x00, f_error = 1, brk = 1, no further words until the line returns high, then 0x7E is received cleanly.
5. ready held 0, frames 0x11 then 0x22 -> d_out stays 0x11, o_error pulses exactly once. ready raised in the same clk as a third frame (0x33) completes -> 0x11 is consumed, valid stays 1, d_out = 0x33.
6. DATA_BITS = 7, STOP_BITS = 2, OVERSAMPLE = 8, rx_in edges jittered ±3% of a bit -> 0x5A received correctly; reset_n pulsed mid-frame -> no valid, outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver, majority-vote sampling,
// parity/frame/break/overrun flags, one-word valid/ready holding reg.
// Ports: clk, reset_n, rx_in, ready -> valid, d_out, f_error,
// p_error, brk, o_error.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 31_250,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 f_error,
  output logic                 p_error,
  output logic                 brk,
  output logic                 o_error
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int PW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_cfg: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, BRK_WAIT
  } state_t;

  state_t state, state_d;

  logic                 rx_q, rx_s;
  logic [PW-1:0]        pcnt;
  logic [SW-1:0]        sub, sub_nx;
  logic                 tick, decide, maj;
  logic                 v_lo, v_mid;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, f_err;
  logic                 fin, f_fin, p_fin, is_brk;
  logic                 last_data, last_stop;
  logic                 done;
  logic [DATA_BITS-1:0] fr_d;
  logic                 fr_f, fr_p, fr_b;

  assign tick   = (pcnt == PW'(DIV - 1));
  assign sub_nx = (sub == SW'(OVERSAMPLE - 1)) ? '0 : sub + 1'b1;
  // sample points are named by the count value the tick produces
  assign decide = tick && (sub_nx == SW'(M + 1));
  assign maj    = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);

  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

  assign f_fin = f_err | ~maj;
  assign p_fin = (PARITY == 1) ? ~(^shreg ^ par_bit) :
                 (PARITY == 2) ?  (^shreg ^ par_bit) : 1'b0;
  assign is_brk = (shreg == '0) && f_fin &&
                  ((PARITY == 0) || !par_bit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    fin     = 1'b0;
    unique case (state)
      IDLE:     if (!rx_s) state_d = START;
      START:    if (decide) state_d = maj ? IDLE : DATA;
      DATA:     if (decide && last_data)
                  state_d = (PARITY != 0) ? PAR : STOP;
      PAR:      if (decide) state_d = STOP;
      STOP:     if (decide && last_stop) begin
                  fin     = 1'b1;
                  state_d = is_brk ? BRK_WAIT : IDLE;
                end
      BRK_WAIT: if (rx_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q    <= 1'b1;
      rx_s    <= 1'b1;
      pcnt    <= '0;
      sub     <= '0;
      v_lo    <= 1'b1;
      v_mid   <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      f_err   <= 1'b0;
      done    <= 1'b0;
      fr_d    <= '0;
      fr_f    <= 1'b0;
      fr_p    <= 1'b0;
      fr_b    <= 1'b0;
    end else begin
      rx_q <= rx_in;
      rx_s <= rx_q;
      // align the bit grid to the start edge
      if (state == IDLE && !rx_s) begin
        pcnt <= '0;
        sub  <= '0;
      end else begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick) sub <= sub_nx;
      end
      if (tick && sub_nx == SW'(M - 1)) v_lo  <= rx_s;
      if (tick && sub_nx == SW'(M))     v_mid <= rx_s;
      if (decide) begin
        bit_cnt <= (state_d != state) ? '0 : bit_cnt + 1'b1;
        unique case (state)
          START: f_err <= 1'b0;
          DATA:  shreg <= {maj, shreg[DATA_BITS-1:1]};
          PAR:   par_bit <= maj;
          STOP:  f_err <= f_fin;
          default: ;
        endcase
      end
      done <= fin;
      if (fin) begin
        fr_d <= shreg;
        fr_f <= f_fin;
        fr_p <= p_fin;
        fr_b <= is_brk;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      d_out   <= '0;
      f_error <= 1'b0;
      p_error <= 1'b0;
      brk     <= 1'b0;
      o_error <= 1'b0;
    end else begin
      o_error <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          valid   <= 1'b1;
          d_out   <= fr_d;
          f_error <= fr_f;
          p_error <= fr_p;
          brk     <= fr_b;
        end else begin
          o_error <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg in four configs.
// Bit time is 32 clk in every config.
module tb_uart_rx_cfg;
  localparam int CF = 1_000_000;

  logic clk = 1'b0;
  logic reset_n;
  logic rx_line;
  logic ready;
  int   sel;

  logic rx0, rx1, rx2, rx3;
  logic v0, f0, p0, b0, oe0;
  logic v1, f1, p1, b1, oe1;
  logic v2, f2, p2, b2, oe2;
  logic v3, f3, p3, b3, oe3;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;

  logic [11:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0] w;
  int n_oe0, n_oe12, n_oe3;
  int n_chk, n_fail;

  assign rx0 = (sel == 0) ? rx_line : 1'b1;
  assign rx1 = (sel == 1) ? rx_line : 1'b1;
  assign rx2 = (sel == 2) ? rx_line : 1'b1;
  assign rx3 = (sel == 3) ? rx_line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(CF)) u0 (
    .clk(clk), .reset_n(reset_n), .rx_in(rx0), .valid(v0),
    .ready(ready), .d_out(d0), .f_error(f0), .p_error(p0),
    .brk(b0), .o_error(oe0));

  uart_rx_cfg #(.CLK_FREQ(CF), .PARITY(2)) u1 (
    .clk(clk), .reset_n(reset_n), .rx_in(rx1), .valid(v1),
    .ready(ready), .d_out(d1), .f_error(f1), .p_error(p1),
    .brk(b1), .o_error(oe1));

  uart_rx_cfg #(.CLK_FREQ(CF), .PARITY(1)) u2 (
    .clk(clk), .reset_n(reset_n), .rx_in(rx2), .valid(v2),
    .ready(ready), .d_out(d2), .f_error(f2), .p_error(p2),
    .brk(b2), .o_error(oe2));

  uart_rx_cfg #(.CLK_FREQ(CF), .OVERSAMPLE(8), .DATA_BITS(7),
                .STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .rx_in(rx3), .valid(v3),
    .ready(ready), .d_out(d3), .f_error(f3), .p_error(p3),
    .brk(b3), .o_error(oe3));

  always @(negedge clk) begin
    #1;
    if (v0 && ready) q0.push_back({b0, p0, f0, 1'b0, d0});
    if (v1 && ready) q1.push_back({b1, p1, f1, 1'b0, d1});
    if (v2 && ready) q2.push_back({b2, p2, f2, 1'b0, d2});
    if (v3 && ready) q3.push_back({b3, p3, f3, 2'b0, d3});
    if (oe0) n_oe0++;
    if (oe1 || oe2) n_oe12++;
    if (oe3) n_oe3++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ent(input logic [8:0] d,
                                      input logic f, input logic p,
                                      input logic b);
    return {b, p, f, d};
  endfunction

  function automatic logic [15:0] mkf(input logic [8:0] d,
                                      input int nd, input int np,
                                      input logic pb, input int ns,
                                      input logic sb);
    logic [15:0] v;
    int k;
    v = '1;
    v[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin v[k] = d[i]; k++; end
    if (np != 0) begin v[k] = pb; k++; end
    for (int i = 0; i < ns; i++) begin v[k] = sb; k++; end
    return v;
  endfunction

  // called on a negedge; each bit held 32 clk, or jittered +-1 clk
  task automatic send(input logic [15:0] v, input int n,
                      input bit jit);
    for (int i = 0; i < n; i++) begin
      int dur;
      rx_line = v[i];
      dur = 32;
      if (jit) dur = (i == 0) ? 33 : ((i % 2) == 1) ? 30 : 34;
      repeat (dur) @(negedge clk);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    n_oe0 = 0; n_oe12 = 0; n_oe3 = 0;
    rx_line = 1'b1; ready = 1'b1; sel = 0; reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_u0", 32'({v0, f0, p0, b0, oe0, d0}), 0);
    check("rst_u3", 32'({v3, f3, p3, b3, oe3, d3}), 0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    // back-to-back bytes
    q0.delete(); n_oe0 = 0;
    for (int i = 0; i < 10; i++)
      send(mkf(9'(16 + i), 8, 0, 1'b0, 1, 1'b1), 10, 1'b0);
    repeat (64) @(negedge clk);
    check("b2b_cnt", q0.size(), 10);
    for (int i = 0; i < 10; i++) begin
      w = (i < q0.size()) ? q0[i] : '1;
      check("b2b_word", 32'(w),
            32'(ent(9'(16 + i), 1'b0, 1'b0, 1'b0)));
    end
    check("b2b_oerr", n_oe0, 0);

    // short glitch is a false start
    q0.delete();
    rx_line = 1'b0;
    repeat (6) @(negedge clk);
    rx_line = 1'b1;
    repeat (64) @(negedge clk);
    check("glitch_cnt", q0.size(), 0);
    check("glitch_v", 32'(v0), 0);
    send(mkf(9'h0A5, 8, 0, 1'b0, 1, 1'b1), 10, 1'b0);
    repeat (32) @(negedge clk);
    check("glitch_next_cnt", q0.size(), 1);
    w = (q0.size() > 0) ? q0[0] : '1;
    check("glitch_next", 32'(w), 32'(ent(9'h0A5, 1'b0, 1'b0, 1'b0)));

    // parity: 0x03 has two ones
    sel = 1; q1.delete(); q2.delete(); n_oe12 = 0;
    send(mkf(9'h003, 8, 1, 1'b1, 1, 1'b1), 11, 1'b0);
    send(mkf(9'h003, 8, 1, 1'b0, 1, 1'b1), 11, 1'b0);
    sel = 2;
    send(mkf(9'h003, 8, 1, 1'b1, 1, 1'b1), 11, 1'b0);
    send(mkf(9'h003, 8, 1, 1'b0, 1, 1'b1), 11, 1'b0);
    repeat (32) @(negedge clk);
    check("par_cnt", q1.size() + q2.size(), 4);
    w = (q1.size() > 0) ? q1[0] : '1;
    check("even_pb1", 32'(w), 32'(ent(9'h003, 1'b0, 1'b1, 1'b0)));
    w = (q1.size() > 1) ? q1[1] : '1;
    check("even_pb0", 32'(w), 32'(ent(9'h003, 1'b0, 1'b0, 1'b0)));
    w = (q2.size() > 0) ? q2[0] : '1;
    check("odd_pb1", 32'(w), 32'(ent(9'h003, 1'b0, 1'b0, 1'b0)));
    w = (q2.size() > 1) ? q2[1] : '1;
    check("odd_pb0", 32'(w), 32'(ent(9'h003, 1'b0, 1'b1, 1'b0)));
    check("par_oerr", n_oe12, 0);

    // frame error, then break
    sel = 0; q0.delete();
    send(mkf(9'h055, 8, 0, 1'b0, 1, 1'b0), 10, 1'b0);
    rx_line = 1'b1;
    repeat (64) @(negedge clk);
    check("ferr_cnt", q0.size(), 1);
    w = (q0.size() > 0) ? q0[0] : '1;
    check("ferr_word", 32'(w), 32'(ent(9'h055, 1'b1, 1'b0, 1'b0)));
    rx_line = 1'b0;
    repeat (640) @(negedge clk);
    check("brk_cnt", q0.size(), 2);
    w = (q0.size() > 1) ? q0[1] : '1;
    check("brk_word", 32'(w), 32'(ent(9'h000, 1'b1, 1'b0, 1'b1)));
    rx_line = 1'b1;
    repeat (64) @(negedge clk);
    send(mkf(9'h07E, 8, 0, 1'b0, 1, 1'b1), 10, 1'b0);
    repeat (32) @(negedge clk);
    check("brk_next_cnt", q0.size(), 3);
    w = (q0.size() > 2) ? q0[2] : '1;
    check("brk_next", 32'(w), 32'(ent(9'h07E, 1'b0, 1'b0, 1'b0)));

    // overrun with a stalled consumer
    ready = 1'b0; q0.delete(); n_oe0 = 0;
    send(mkf(9'h011, 8, 0, 1'b0, 1, 1'b1), 10, 1'b0);
    check("ovr_first", 32'({v0, d0}), 32'({1'b1, 8'h11}));
    send(mkf(9'h022, 8, 0, 1'b0, 1, 1'b1), 10, 1'b0);
    check("ovr_hold", 32'({v0, d0}), 32'({1'b1, 8'h11}));
    check("ovr_pulse", n_oe0, 1);
    repeat (32) @(negedge clk);
    // completion lands on the 310th posedge after the start edge
    fork
      send(mkf(9'h033, 8, 0, 1'b0, 1, 1'b1), 10, 1'b0);
      begin
        repeat (309) @(negedge clk);
        ready = 1'b1;
        check("sim_pre", 32'({v0, d0}), 32'({1'b1, 8'h11}));
        @(negedge clk);
        #2;
        check("sim_post", 32'({v0, d0}), 32'({1'b1, 8'h33}));
        check("sim_oerr", n_oe0, 1);
      end
    join
    repeat (8) @(negedge clk);
    check("sim_cnt", q0.size(), 2);
    w = (q0.size() > 1) ? q0[1] : '1;
    check("sim_word", 32'(w), 32'(ent(9'h033, 1'b0, 1'b0, 1'b0)));

    // 7 data bits, 2 stop, 8x oversampling, jittered edges
    sel = 3; ready = 1'b0; q3.delete();
    send(mkf(9'h05A, 7, 0, 1'b0, 2, 1'b1), 10, 1'b1);
    check("jit_word", 32'({v3, b3, p3, f3, d3}),
          32'({1'b1, 3'b000, 7'h5A}));
    send(mkf(9'h033, 7, 0, 1'b0, 2, 1'b1), 4, 1'b0);
    reset_n = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst", 32'({v3, f3, p3, b3, oe3, d3}), 0);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    check("mid_rst_nov", 32'(v3), 0);
    check("mid_rst_oerr", n_oe3, 0);
    ready = 1'b1;
    send(mkf(9'h02C, 7, 0, 1'b0, 2, 1'b1), 10, 1'b0);
    repeat (16) @(negedge clk);
    check("post_rst_cnt", q3.size(), 1);
    w = (q3.size() > 0) ? q3[0] : '1;
    check("post_rst", 32'(w), 32'(ent(9'h02C, 1'b0, 1'b0, 1'b0)));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
